student_or: RTL and testbench

- Bitwise 2-input OR gate, the project-1 OR primitive, used by higher-level logic in the course gate library.
- Primary output `out` is purely combinational (a | b). It is valid with no clock running and during reset.
- Adds an optional registered copy, a registered reduction flag and a sticky accumulator for clocked users. These share one clock and one async active-low reset.

---
 rtl/student_or_if.sv | 13 +
 rtl/student_or.sv | 32 +++
 tb/tb_student_or.sv | 137 +++++++++++++
 3 files changed

// File: rtl/student_or_if.sv
// student_or_if: operand, control and result signals of the student_or gate
interface student_or_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             any_q;
  logic [WIDTH-1:0] sticky_q;
  modport master (output a, b, en, clr, input out, out_q, any_q, sticky_q);
  modport slave  (input a, b, en, clr, output out, out_q, any_q, sticky_q);
endinterface

// File: rtl/student_or.sv
// student_or: bitwise OR gate with registered copy, reduction flag and sticky accumulator
module student_or #(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  student_or_if.slave bus
);
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] out_r;
  logic             any_r;
  logic [WIDTH-1:0] sticky_r;
  assign or_v         = bus.a | bus.b;
  assign bus.out      = or_v;
  assign bus.out_q    = out_r;
  assign bus.any_q    = any_r;
  assign bus.sticky_q = sticky_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= '0;
      any_r    <= 1'b0;
      sticky_r <= '0;
    end else begin
      if (bus.en) begin
        out_r <= or_v;
        any_r <= |or_v;
      end
      // clear keeps the current sample so a coincident event is not lost
      sticky_r <= bus.clr ? or_v : (sticky_r | or_v);
    end
  end
endmodule

// File: tb/tb_student_or.sv
// tb_student_or: truth table, directed clocked sequences and randomized model check
module tb_student_or;
  typedef struct {logic a; logic b; logic y;} tt_t;
  logic clk = 1'b0;
  logic run = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  tt_t tt[4];
  logic [3:0] hist[$];
  logic [3:0] ra, rb, eoq, es;
  logic ren, rclr, eany;
  student_or_if #(.WIDTH(1)) i1 ();
  student_or_if #(.WIDTH(4)) i4 ();
  student_or #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  student_or #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  always #5 if (run) clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask
  task automatic set1(input logic a, input logic b, input logic en, input logic clr);
    i1.a = a; i1.b = b; i1.en = en; i1.clr = clr;
  endtask
  task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic en, input logic clr);
    i4.a = a; i4.b = b; i4.en = en; i4.clr = clr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b1};
    tt[2] = '{1'b1, 1'b0, 1'b1};
    tt[3] = '{1'b1, 1'b1, 1'b1};
    set1(0, 0, 0, 0);
    set4(0, 0, 0, 0);
    #1 rst_n = 1'b1;
    $display("| a | b |out|");
    for (int i = 0; i < 4; i++) begin
      set1(tt[i].a, tt[i].b, 0, 0);
      #(i + 1);
      $display("| %b | %b | %b |", tt[i].a, tt[i].b, i1.out);
      chk("tt_out", {3'b0, i1.out}, {3'b0, tt[i].y});
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set1(tt[i].a, tt[i].b, 1, 0);
      #(i + 1);
      chk("rst_tt_out", {3'b0, i1.out}, {3'b0, tt[i].y});
      chk("rst_regs", {1'b0, i1.out_q, i1.any_q, i1.sticky_q}, 4'b0);
    end
    set1(1'bx, 1'b1, 0, 0);
    #1 chk("x_or_1", {3'b0, i1.out}, 4'b0001);
    set1(1'bx, 1'b0, 0, 0);
    #1 chk("x_or_0", {3'b0, i1.out}, 4'b000x);
    set1(0, 0, 0, 0);
    #1 rst_n = 1'b1;
    run = 1'b1;
    tick();
    chk("idle_out_q", {3'b0, i1.out_q}, 4'b0);
    set1(1, 0, 1, 0);
    #1 chk("pre_edge_out_q", {2'b0, i1.out_q, i1.any_q}, 4'b0);
    tick();
    chk("edge_out_q_any", {2'b0, i1.out_q, i1.any_q}, 4'b0011);
    set1(0, 0, 0, 0);
    tick();
    chk("hold_out_q_any", {2'b0, i1.out_q, i1.any_q}, 4'b0011);
    set1(1, 0, 0, 0);
    tick();
    set1(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sticky_hold", {3'b0, i1.sticky_q}, 4'b0001);
    end
    set1(0, 0, 0, 1);
    tick();
    chk("sticky_clr", {3'b0, i1.sticky_q}, 4'b0);
    set1(0, 1, 0, 1);
    tick();
    chk("sticky_clr_keep", {3'b0, i1.sticky_q}, 4'b0001);
    set1(1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_regs", {2'b0, i1.out_q, i1.sticky_q}, 4'b0);
    chk("async_rst_out", {3'b0, i1.out}, 4'b0001);
    rst_n = 1'b1;
    set1(0, 1, 1, 0);
    tick();
    chk("post_rst_load", {1'b0, i1.out_q, i1.any_q, i1.sticky_q}, 4'b0111);
    set4(4'b1010, 4'b0101, 0, 0);
    #1 chk("w4_out_full", i4.out, 4'b1111);
    set4(0, 0, 1, 0);
    #1 chk("w4_out_zero", i4.out, 4'b0);
    tick();
    chk("w4_any_zero", {3'b0, i4.any_q}, 4'b0);
    set4(4'b0001, 0, 1, 0);
    tick();
    chk("w4_any_one", {3'b0, i4.any_q}, 4'b0001);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    eoq = '0;
    eany = 1'b0;
    hist.delete();
    for (int n = 0; n < 200; n++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      ren = ($urandom_range(0, 3) != 0);
      rclr = ($urandom_range(0, 7) == 0);
      set4(ra, rb, ren, rclr);
      #1 chk("rnd_out", i4.out, ra | rb);
      tick();
      if (ren) begin
        eoq = ra | rb;
        eany = (ra | rb) != 4'd0;
      end
      if (rclr) hist.delete();
      hist.push_back(ra | rb);
      es = '0;
      foreach (hist[k]) es = es | hist[k];
      chk("rnd_out_q", i4.out_q, eoq);
      chk("rnd_any_q", {3'b0, i4.any_q}, {3'b0, eany});
      chk("rnd_sticky", i4.sticky_q, es);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
